// File: rtl/dreg_sched_pkg.sv
// Shared definitions for the round-robin holding-register scheduler.
package dreg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    ACK       = 2'd2
  } state_e;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 4;
  localparam int unsigned DIV_W_DEF   = 27;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-clock enable at terminal count.
module tick_prescaler #(
  parameter int unsigned DIV_W = 27
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] count_q;

  // Counter increments every clock and wraps; only reset touches it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_q + DIV_W'(1);
  end

  assign tick = (count_q == '1);

endmodule

// File: rtl/dreg_rr_scheduler.sv
// Round-robin scheduler sharing one holding register, committed on prescaler ticks.
module dreg_rr_scheduler
  import dreg_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned DIV_W   = DIV_W_DEF,
  localparam int unsigned OW      = owner_w(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic                      clear,
  output logic [DATA_W-1:0]         Data_out,
  output logic [NUM_REQ-1:0]        grant,
  output logic [OW-1:0]             owner,
  output logic                      busy,
  output logic                      tick
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [DATA_W-1:0] snap_q,  snap_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     win_q,   win_d;
  logic [OW-1:0]     rr_q,    rr_d;
  logic [OW-1:0]     pick_idx;
  logic [DATA_W-1:0] words [NUM_REQ];

  tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  // First set request bit found searching upward from ptr+1, wrapping.
  function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0] ptr,
                                            input logic [NUM_REQ-1:0] r);
    logic [OW-1:0] win;
    logic [OW-1:0] cand;
    logic          found;
    int unsigned   idx;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(ptr) + k) % NUM_REQ;
      cand = OW'(idx);
      if (!found && r[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign pick_idx = rr_pick(rr_q, req);

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      snap_q  <= '0;
      owner_q <= '0;
      win_q   <= '0;
      rr_q    <= OW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      snap_q  <= snap_d;
      owner_q <= owner_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic; clear overrides everything except owner and the rr pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    snap_d  = snap_q;
    owner_d = owner_q;
    win_d   = win_q;
    rr_d    = rr_q;
    grant   = '0;
    if (state_q == ACK) grant[owner_q] = 1'b1;
    if (clear) begin
      state_d = IDLE;
      data_d  = '0;
      snap_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_d   = pick_idx;
            snap_d  = words[pick_idx];
            state_d = WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            data_d  = snap_q;
            owner_d = win_q;
            rr_d    = win_q;
            state_d = ACK;
          end
        end
        ACK:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign Data_out = data_q;
  assign owner    = owner_q;
  assign busy     = (state_q != IDLE);

endmodule
